clause_result_collector: RTL

Collects per-clause terminal outputs (implication drive, conflict drive, max decision level) from the clause array and serialises them toward the engine controller. On a start pulse it snapshots all clause results, then emits either one conflict report or one implication report per implying clause over a valid/ready handshake, and signals completion. It is the consuming end of the terminal-cell outputs of the clause array.

---
 rtl/clause_result_collector.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/clause_result_collector.sv
// Snapshots clause-array terminal outputs on start and serialises them as
// conflict/implication reports over valid/ready. Define CONFLICT_MAXLVL_EN to report backtrack level.
module clause_result_collector #(
  parameter int unsigned NUM_C     = 8,
  parameter int unsigned WIDTH_C   = 3,
  parameter int unsigned WIDTH_LVL = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [NUM_C-1:0]           imp_drv_i,
  input  logic [NUM_C-1:0]           cclause_drv_i,
  input  logic [NUM_C*WIDTH_LVL-1:0] max_lvl_i,
  output logic                       rpt_valid_o,
  input  logic                       rpt_ready_i,
  output logic                       rpt_kind_o,
  output logic [WIDTH_C-1:0]         rpt_cidx_o,
  output logic [WIDTH_LVL-1:0]       rpt_lvl_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       conflict_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REPORT = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [NUM_C-1:0]           imp_pend_q, imp_pend_d;
  logic [NUM_C-1:0]           cf_pend_q, cf_pend_d;
  logic [NUM_C*WIDTH_LVL-1:0] lvl_snap_q, lvl_snap_d;
  logic                       conflict_q, conflict_d;

  // Lowest pending implication: index, one-hot mask and its snapped level
  logic                 imp_found;
  logic [WIDTH_C-1:0]   imp_idx;
  logic [NUM_C-1:0]     imp_onehot;
  logic [WIDTH_LVL-1:0] imp_lvl;

  always_comb begin
    imp_found  = 1'b0;
    imp_idx    = '0;
    imp_onehot = '0;
    imp_lvl    = '0;
    for (int unsigned i = 0; i < NUM_C; i++) begin
      if (imp_pend_q[i] && !imp_found) begin
        imp_found     = 1'b1;
        imp_idx       = WIDTH_C'(i);
        imp_onehot[i] = 1'b1;
        imp_lvl       = lvl_snap_q[i*WIDTH_LVL +: WIDTH_LVL];
      end
    end
  end

  logic                 cf_found;
  logic [WIDTH_C-1:0]   cf_idx;
  logic [WIDTH_LVL-1:0] cf_lvl;

`ifdef CONFLICT_MAXLVL_EN
  // Backtrack level: unsigned max over every conflicting clause
  always_comb begin
    cf_found = 1'b0;
    cf_idx   = '0;
    cf_lvl   = '0;
    for (int unsigned i = 0; i < NUM_C; i++) begin
      if (cf_pend_q[i]) begin
        if (!cf_found) begin
          cf_found = 1'b1;
          cf_idx   = WIDTH_C'(i);
        end
        if (lvl_snap_q[i*WIDTH_LVL +: WIDTH_LVL] > cf_lvl)
          cf_lvl = lvl_snap_q[i*WIDTH_LVL +: WIDTH_LVL];
      end
    end
  end
`else
  always_comb begin
    cf_found = 1'b0;
    cf_idx   = '0;
    cf_lvl   = '0;
    for (int unsigned i = 0; i < NUM_C; i++) begin
      if (cf_pend_q[i] && !cf_found) begin
        cf_found = 1'b1;
        cf_idx   = WIDTH_C'(i);
        cf_lvl   = lvl_snap_q[i*WIDTH_LVL +: WIDTH_LVL];
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    imp_pend_d  = imp_pend_q;
    cf_pend_d   = cf_pend_q;
    lvl_snap_d  = lvl_snap_q;
    conflict_d  = conflict_q;
    rpt_valid_o = 1'b0;
    rpt_kind_o  = 1'b0;
    rpt_cidx_o  = '0;
    rpt_lvl_o   = '0;
    done_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          imp_pend_d = imp_drv_i;
          cf_pend_d  = cclause_drv_i;
          lvl_snap_d = max_lvl_i;
          conflict_d = 1'b0;
          state_d    = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (cf_found) begin
          rpt_valid_o = 1'b1;
          rpt_kind_o  = 1'b1;
          rpt_cidx_o  = cf_idx;
          rpt_lvl_o   = cf_lvl;
          if (rpt_ready_i) begin
            // A conflict supersedes every pending implication
            cf_pend_d  = '0;
            imp_pend_d = '0;
            conflict_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else if (imp_found) begin
          rpt_valid_o = 1'b1;
          rpt_cidx_o  = imp_idx;
          rpt_lvl_o   = imp_lvl;
          if (rpt_ready_i)
            imp_pend_d = imp_pend_q & ~imp_onehot;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      imp_pend_q <= '0;
      cf_pend_q  <= '0;
      lvl_snap_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      imp_pend_q <= imp_pend_d;
      cf_pend_q  <= cf_pend_d;
      lvl_snap_q <= lvl_snap_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign conflict_o = conflict_q;

endmodule
